// File: rtl/ctrl_pipe_pkg.sv
// Shared constants and types for the post-decode control pipeline.
// Stage indices follow E/M/W naming of the classic five-stage core.
package ctrl_pipe_pkg;

  localparam int STG_E = 0;
  localparam int STG_M = 1;
  localparam int STG_W = 2;

  localparam int CW_DEF = 14;

  typedef logic [CW_DEF-1:0] ctrl_word_t;

endpackage

// File: rtl/ctrl_pipe_stage.sv
// One control-word stage register.
// Update order: flush, hold, bubble, load.
module ctrl_pipe_stage #(
  parameter int CW = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          hold,
  input  logic          bubble,
  input  logic [CW-1:0] d,
  input  logic          dv,
  output logic [CW-1:0] q,
  output logic          qv
);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      q  <= '0;
      qv <= 1'b0;
    end else if (!hold) begin
      if (bubble) begin
        q  <= '0;
        qv <= 1'b0;
      end else begin
        q  <= d;
        qv <= dv;
      end
    end
  end

endmodule

// File: rtl/ctrl_pipeline.sv
// Parametrised control-word pipeline with per-stage stall/flush
// and a mult/div busy tracker guarding HI/LO accesses.
module ctrl_pipeline
  import ctrl_pipe_pkg::*;
#(
  parameter int CW         = CW_DEF,
  parameter int NSTAGES    = 3,
  parameter int MD_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CW-1:0]         ctrl_d,
  input  logic                  valid_d,
  input  logic                  md_start_d,
  input  logic                  hl_use_d,
  input  logic [NSTAGES-1:0]    stall_i,
  input  logic [NSTAGES-1:0]    flush_i,
  output logic [NSTAGES*CW-1:0] ctrl_o,
  output logic [NSTAGES-1:0]    valid_o,
  output logic                  stall_d_o,
  output logic                  md_busy_o,
  output logic                  md_done_o
);

  localparam int CNTW = $clog2(MD_LATENCY + 1);
  localparam logic [CNTW-1:0] LAT = CNTW'(MD_LATENCY);

  logic [NSTAGES-1:0] stall_eff;
  logic [CNTW-1:0]    cnt;
  logic               md_e;
  logic               md_in_e;
  logic               md_hazard;
  logic               md_load;

  // A stall anywhere downstream freezes every stage above it.
  always_comb begin
    stall_eff = '0;
    stall_eff[NSTAGES-1] = stall_i[NSTAGES-1];
    for (int k = NSTAGES - 2; k >= 0; k--) begin
      stall_eff[k] = stall_i[k] | stall_eff[k+1];
    end
  end

  assign md_busy_o = (cnt != '0);
  assign md_in_e   = md_e & valid_o[STG_E];
  assign md_hazard = valid_d & hl_use_d & (md_busy_o | md_in_e);
  assign stall_d_o = stall_eff[STG_E] | md_hazard;

  assign md_load = valid_d & md_start_d & ~flush_i[STG_E]
                 & ~stall_eff[STG_E] & ~md_hazard;

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stg
    logic [CW-1:0] d;
    logic          dv;
    logic          bub;

    if (k == 0) begin : g_e
      assign d   = ctrl_d;
      assign dv  = valid_d;
      assign bub = md_hazard;
    end else begin : g_n
      assign d   = ctrl_o[(k-1)*CW +: CW];
      assign dv  = valid_o[k-1];
      assign bub = stall_eff[k-1];
    end

    ctrl_pipe_stage #(.CW(CW)) u_stg (
      .clk    (clk),
      .reset  (reset),
      .flush  (flush_i[k]),
      .hold   (stall_eff[k]),
      .bubble (bub),
      .d      (d),
      .dv     (dv),
      .q      (ctrl_o[k*CW +: CW]),
      .qv     (valid_o[k])
    );
  end

  // Tracks whether the word in stage E is the mult/div itself.
  always_ff @(posedge clk) begin
    if (reset || flush_i[STG_E]) begin
      md_e <= 1'b0;
    end else if (!stall_eff[STG_E]) begin
      md_e <= md_hazard ? 1'b0 : (valid_d & md_start_d);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      md_done_o <= 1'b0;
    end else begin
      md_done_o <= 1'b0;
      if (flush_i[STG_E] && md_in_e) begin
        cnt <= '0;
      end else if (md_load) begin
        cnt <= LAT;
      end else if (cnt != '0) begin
        cnt       <= cnt - 1'b1;
        md_done_o <= (cnt == CNTW'(1));
      end
    end
  end

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Scoreboard bench for ctrl_pipeline: driver feeds a reference model,
// monitor compares registered outputs each cycle.
module tb_ctrl_pipeline;

  localparam int CW  = 14;
  localparam int N   = 3;
  localparam int LAT = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [CW-1:0]     ctrl_d;
  logic              valid_d;
  logic              md_start_d;
  logic              hl_use_d;
  logic [N-1:0]      stall_i;
  logic [N-1:0]      flush_i;
  logic [N*CW-1:0]   ctrl_o;
  logic [N-1:0]      valid_o;
  logic              stall_d_o;
  logic              md_busy_o;
  logic              md_done_o;

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    logic [N*CW-1:0] c;
    logic [N-1:0]    v;
    logic            busy;
    logic            done;
  } exp_t;

  exp_t exp_q[$];

  // Reference state: stage contents, md flag for E, cycles left.
  logic [CW-1:0] mc [N];
  logic          mv [N];
  logic          m_md;
  int            m_left;
  bit            known = 0;

  ctrl_pipeline #(.CW(CW), .NSTAGES(N), .MD_LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .ctrl_d     (ctrl_d),
    .valid_d    (valid_d),
    .md_start_d (md_start_d),
    .hl_use_d   (hl_use_d),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .ctrl_o     (ctrl_o),
    .valid_o    (valid_o),
    .stall_d_o  (stall_d_o),
    .md_busy_o  (md_busy_o),
    .md_done_o  (md_done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, check stall_d_o, advance the model, queue expectation.
  task automatic step(input logic [CW-1:0] c, input logic v, input logic md,
                      input logic hl, input logic [N-1:0] st,
                      input logic [N-1:0] fl, input logic rst,
                      output logic sd);
    logic          se [N];
    logic          haz;
    logic          mdin;
    logic [CW-1:0] oc [N];
    logic          ov [N];
    bit            done;
    exp_t          e;
    @(negedge clk);
    ctrl_d = c; valid_d = v; md_start_d = md; hl_use_d = hl;
    stall_i = st; flush_i = fl; reset = rst;
    #1;
    for (int k = 0; k < N; k++) begin
      se[k] = 1'b0;
      for (int j = k; j < N; j++) se[k] = se[k] | st[j];
    end
    mdin = m_md & mv[0];
    haz  = v & hl & ((m_left > 0) | mdin);
    sd   = stall_d_o;
    if (known) check("stall_d", stall_d_o, se[0] | haz);
    for (int k = 0; k < N; k++) begin oc[k] = mc[k]; ov[k] = mv[k]; end
    done = 0;
    if (rst) begin
      for (int k = 0; k < N; k++) begin mc[k] = '0; mv[k] = 0; end
      m_md = 0; m_left = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (fl[k]) begin mc[k] = '0; mv[k] = 0; end
        else if (se[k]) begin end
        else if (k > 0 ? se[k-1] : haz) begin mc[k] = '0; mv[k] = 0; end
        else if (k == 0) begin mc[0] = c; mv[0] = v; end
        else begin mc[k] = oc[k-1]; mv[k] = ov[k-1]; end
      end
      if (fl[0] && mdin) m_left = 0;
      else if (v && md && !fl[0] && !se[0] && !haz) m_left = LAT;
      else if (m_left > 0) begin
        m_left--;
        done = (m_left == 0);
      end
      if (fl[0]) m_md = 0;
      else if (!se[0]) m_md = haz ? 1'b0 : (v & md);
    end
    for (int k = 0; k < N; k++) begin
      e.c[k*CW +: CW] = mc[k];
      e.v[k] = mv[k];
    end
    e.busy = (m_left > 0);
    e.done = done;
    exp_q.push_back(e);
    @(posedge clk);
    if (rst) known = 1;
  endtask

  task automatic idle(output logic sd);
    step('0, 0, 0, 0, '0, '0, 0, sd);
  endtask

  // Monitor: outputs are presented every cycle, compare #1 after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ctrl_o", ctrl_o, e.c);
        check("valid_o", valid_o, e.v);
        check("md_busy", md_busy_o, e.busy);
        check("md_done", md_done_o, e.done);
      end
    end
  end

  initial begin
    logic sd;
    int   busy_n, done_n, stall_n;
    bit   loaded, prev_done;
    ctrl_d = '0; valid_d = 0; md_start_d = 0; hl_use_d = 0;
    stall_i = '0; flush_i = '0; reset = 1;
    for (int k = 0; k < N; k++) begin mc[k] = '0; mv[k] = 0; end
    m_md = 0; m_left = 0;

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      logic md;
      md = 1'($urandom);
      step(CW'($urandom), 1'($urandom), md, md | 1'($urandom),
           N'($urandom), N'($urandom), 1, sd);
    end
    #2;
    check("rst_ctrl", ctrl_o, '0);
    check("rst_valid", valid_o, '0);
    idle(sd);
    #2;
    check("post_rst_busy", md_busy_o, 0);
    check("post_rst_stall_d", sd, 0);

    // Flow
    step(14'h2A5, 1, 0, 0, '0, '0, 0, sd);
    #2 check("flow_s0", ctrl_o[0 +: CW], 14'h2A5);
    idle(sd);
    #2 check("flow_s1", ctrl_o[CW +: CW], 14'h2A5);
    idle(sd);
    #2 check("flow_s2", ctrl_o[2*CW +: CW], 14'h2A5);

    // Bubble
    step(14'h111, 1, 0, 0, '0, '0, 0, sd);
    step(14'h222, 1, 0, 0, 3'b001, '0, 0, sd);
    check("bub_stall_d", sd, 1);
    #2;
    check("bub_s0_hold", ctrl_o[0 +: CW], 14'h111);
    check("bub_s1_valid", valid_o[1], 0);

    // Flush wins over stall
    step(14'h222, 1, 0, 0, 3'b010, 3'b010, 0, sd);
    check("fs_stall_d", sd, 1);
    #2;
    check("fs_s1_valid", valid_o[1], 0);
    check("fs_s1_ctrl", ctrl_o[CW +: CW], '0);
    check("fs_s0_hold", ctrl_o[0 +: CW], 14'h111);
    for (int i = 0; i < 3; i++) idle(sd);

    // Mult followed by mfhi
    busy_n = 0; done_n = 0; stall_n = 0; loaded = 0; prev_done = 0;
    step(14'h333, 1, 1, 1, '0, '0, 0, sd);
    #2 busy_n += int'(md_busy_o);
    for (int i = 0; i < 10 && !loaded; i++) begin
      step(14'h044, 1, 0, 1, '0, '0, 0, sd);
      if (sd) stall_n++;
      else loaded = 1;
      #2;
      if (loaded) begin
        check("md_prev_done", prev_done, 1);
        check("mfhi_s0", ctrl_o[0 +: CW], 14'h044);
        check("mfhi_v0", valid_o[0], 1);
      end
      busy_n += int'(md_busy_o);
      done_n += int'(md_done_o);
      prev_done = md_done_o;
    end
    check("mfhi_loaded", loaded, 1);
    check("md_stall_cycles", stall_n, 4);
    check("md_busy_cycles", busy_n, 4);
    check("md_done_pulses", done_n, 1);
    for (int i = 0; i < 3; i++) idle(sd);

    // Mult cancelled by an E flush
    step(14'h355, 1, 1, 1, '0, '0, 0, sd);
    step('0, 0, 0, 0, '0, 3'b001, 0, sd);
    #2 check("cancel_busy", md_busy_o, 0);
    done_n = 0;
    for (int i = 0; i < 6; i++) begin
      idle(sd);
      #2 done_n += int'(md_done_o);
    end
    check("cancel_no_done", done_n, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic          v, md, hl, rst;
      logic [N-1:0]  st, fl;
      v   = ($urandom % 4) != 0;
      md  = v && (($urandom % 6) == 0);
      hl  = md || (($urandom % 5) == 0);
      for (int k = 0; k < N; k++) begin
        st[k] = ($urandom % 8) == 0;
        fl[k] = ($urandom % 16) == 0;
      end
      rst = ($urandom % 250) == 0;
      step(CW'($urandom), v, md, hl, st, fl, rst, sd);
    end
    idle(sd);
    #3;
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
